// File: rtl/match_event_logger.sv
// Timestamped match-event logger: free-running cycle counter, small event FIFO,
// saturating total-match counter and sticky overflow flag.
module match_event_logger #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     match_i,
  input  logic                     clear_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [TS_W-1:0]          evt_ts_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic [CNT_W-1:0]         match_cnt_o,
  output logic                     ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TS_W-1:0]  mem_q [DEPTH];

  logic empty, full, push, pop;

  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LW'(DEPTH));
    pop   = !empty && evt_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push  = match_i && (!full || pop);

    ts_d   = ts_q + TS_W'(1);
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    cnt_d = (match_i && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d = ovf_q | (match_i && !push);

    if (clear_i) begin
      ts_d    = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; the level counter alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !clear_i && push) begin
      mem_q[wptr_q] <= ts_q;
    end
  end

  assign evt_valid_o  = !empty;
  assign evt_ts_o     = mem_q[rptr_q];
  assign fifo_level_o = level_q;
  assign match_cnt_o  = cnt_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_match_event_logger.sv
// Self-checking bench for match_event_logger: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_match_event_logger;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        match_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        evt_ready_i = 1'b0;
  logic        evt_valid_o;
  logic [15:0] evt_ts_o;
  logic [2:0]  fifo_level_o;
  logic [3:0]  match_cnt_o;
  logic        ovf_o;

  match_event_logger #(
    .TS_W  (16),
    .DEPTH (DEPTH),
    .CNT_W (4)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .match_i      (match_i),
    .clear_i      (clear_i),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_ts_o     (evt_ts_o),
    .fifo_level_o (fifo_level_o),
    .match_cnt_o  (match_cnt_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: the FIFO is a queue of timestamps, counters are plain ints.
  int          m_ts = 0;
  logic [15:0] m_q[$];
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;

  always @(posedge clk) begin
    if (reset_i || clear_i) begin
      m_ts = 0;
      m_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      if (m_q.size() > 0 && evt_ready_i) void'(m_q.pop_front());
      if (match_i) begin
        if (m_q.size() < DEPTH) m_q.push_back(16'(m_ts));
        else m_ovf = 1'b1;
        if (m_cnt < 15) m_cnt++;
      end
      m_ts = (m_ts + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_valid", 32'(evt_valid_o), 32'(m_q.size() != 0));
      chk("m_level", 32'(fifo_level_o), 32'(m_q.size()));
      chk("m_cnt",   32'(match_cnt_o), 32'(m_cnt));
      chk("m_ovf",   32'(ovf_o), 32'(m_ovf));
      if (m_q.size() != 0) chk("m_ts", 32'(evt_ts_o), 32'(m_q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; match_i = 1'b0; clear_i = 1'b0; evt_ready_i = 1'b0;
    step();
    cmp_en = 1'b1;
    chk("rst_valid", 32'(evt_valid_o), 32'd0);
    chk("rst_level", 32'(fifo_level_o), 32'd0);
    chk("rst_cnt",   32'(match_cnt_o), 32'd0);
    chk("rst_ovf",   32'(ovf_o), 32'd0);
    reset_i = 1'b0;
  endtask

  task automatic wait_ts(int target);
    int n = 0;
    while (m_ts != target && n < 70000) begin
      step();
      n++;
    end
    chk("wait_ts_timeout", 32'(m_ts), 32'(target));
  endtask

  task automatic drain_expect(string name, int exp0, int exp1, int exp2, int exp3, int cnt);
    int exps[4];
    exps = '{exp0, exp1, exp2, exp3};
    evt_ready_i = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      chk(name, 32'(evt_ts_o), 32'(exps[i]));
      step();
    end
    evt_ready_i = 1'b0;
    chk({name, "_empty"}, 32'(evt_valid_o), 32'd0);
  endtask

  initial begin
    // Single match at ts=5 appears one cycle later.
    do_reset();
    wait_ts(5);
    match_i = 1'b1;
    step();
    match_i = 1'b0;
    chk("s1_valid", 32'(evt_valid_o), 32'd1);
    chk("s1_ts",    32'(evt_ts_o), 32'd5);
    chk("s1_level", 32'(fifo_level_o), 32'd1);
    chk("s1_cnt",   32'(match_cnt_o), 32'd1);
    step(); step();
    chk("s1_hold_ts", 32'(evt_ts_o), 32'd5);

    // Five matches into a depth-4 FIFO: one drop, overflow set.
    do_reset();
    wait_ts(10);
    match_i = 1'b1;
    repeat (5) step();
    match_i = 1'b0;
    chk("s2_level", 32'(fifo_level_o), 32'd4);
    chk("s2_ovf",   32'(ovf_o), 32'd1);
    chk("s2_cnt",   32'(match_cnt_o), 32'd5);
    drain_expect("s2_pop", 10, 11, 12, 13, 4);
    chk("s2_ovf_sticky", 32'(ovf_o), 32'd1);

    // Full FIFO with simultaneous push and pop at ts=20.
    do_reset();
    wait_ts(16);
    match_i = 1'b1;
    repeat (4) step();
    evt_ready_i = 1'b1;
    chk("s3_ts_at_20", 32'(m_ts), 32'd20);
    step();
    match_i = 1'b0; evt_ready_i = 1'b0;
    chk("s3_level", 32'(fifo_level_o), 32'd4);
    chk("s3_ovf",   32'(ovf_o), 32'd0);
    drain_expect("s3_pop", 17, 18, 19, 20, 4);

    // Clear with a coincident match while holding 3 events and overflow.
    do_reset();
    match_i = 1'b1;
    repeat (5) step();
    match_i = 1'b0; evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;
    chk("s4_pre_level", 32'(fifo_level_o), 32'd3);
    chk("s4_pre_ovf",   32'(ovf_o), 32'd1);
    clear_i = 1'b1; match_i = 1'b1; evt_ready_i = 1'b1;
    step();
    clear_i = 1'b0; match_i = 1'b0; evt_ready_i = 1'b0;
    chk("s4_level", 32'(fifo_level_o), 32'd0);
    chk("s4_valid", 32'(evt_valid_o), 32'd0);
    chk("s4_cnt",   32'(match_cnt_o), 32'd0);
    chk("s4_ovf",   32'(ovf_o), 32'd0);
    match_i = 1'b1;
    step();
    match_i = 1'b0;
    chk("s4_ts_restart", 32'(evt_ts_o), 32'd0);
    chk("s4_cnt_after",  32'(match_cnt_o), 32'd1);

    // Saturation of the 4-bit match counter, with streaming push+pop.
    do_reset();
    match_i = 1'b1; evt_ready_i = 1'b1;
    repeat (17) step();
    chk("s5_cnt_sat", 32'(match_cnt_o), 32'd15);
    chk("s5_level",   32'(fifo_level_o), 32'd1);
    repeat (3) step();
    match_i = 1'b0; evt_ready_i = 1'b0;
    chk("s5_cnt_hold", 32'(match_cnt_o), 32'd15);

    // Timestamp wrap: matches at 65535 and 0.
    do_reset();
    wait_ts(65535);
    match_i = 1'b1;
    repeat (2) step();
    match_i = 1'b0;
    chk("s6_level", 32'(fifo_level_o), 32'd2);
    drain_expect("s6_pop", 65535, 0, 0, 0, 2);

    // Reset in the middle of activity discards stored events.
    match_i = 1'b1;
    repeat (3) step();
    match_i = 1'b0;
    do_reset();
    step();
    chk("s7_level", 32'(fifo_level_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
